// File: rtl/ext_irq_ctrl_pkg.sv
// Shared types, register offsets and the coalescer state encoding for ext_irq_ctrl.
// The register-bus structs follow the reg_pkg request/response layout.
package ext_irq_ctrl_pkg;

  localparam logic [2:0] OFF_PENDING = 3'd0;
  localparam logic [2:0] OFF_ENABLE  = 3'd1;
  localparam logic [2:0] OFF_MODE    = 3'd2;
  localparam logic [2:0] OFF_THRESH  = 3'd3;
  localparam logic [2:0] OFF_TIMEOUT = 3'd4;
  localparam logic [2:0] OFF_COAL    = 3'd5;

  localparam int COAL_STATE_W = 2;

  typedef enum logic [COAL_STATE_W-1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FIRE  = 2'd2
  } coal_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

  // Expands byte strobes into a per-bit write mask.
  function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{strb[b]}};
    return m;
  endfunction

endpackage

// File: rtl/ext_irq_coalescer.sv
// Interrupt coalescer: counts enabled events (saturating) and raises one line
// when the count reaches a threshold or a timeout expires, until acknowledged.
module ext_irq_coalescer
  import ext_irq_ctrl_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int CNT_W = 8,
  parameter int TMR_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [N_CH-1:0]   ev_mask_i,
  input  logic [CNT_W-1:0]  thresh_i,
  input  logic [TMR_W-1:0]  timeout_i,
  input  logic              ack_i,
  output logic [CNT_W-1:0]  cnt_o,
  output coal_state_e       state_o,
  output logic              irq_coal_o
);

  localparam int NEW_W = $clog2(N_CH + 1);
  localparam int SUM_W = ((CNT_W > NEW_W) ? CNT_W : NEW_W) + 1;

  function automatic logic [NEW_W-1:0] popcount(input logic [N_CH-1:0] v);
    logic [NEW_W-1:0] c;
    c = '0;
    for (int i = 0; i < N_CH; i++) c = c + NEW_W'(v[i]);
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [NEW_W-1:0] b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    if (s > SUM_W'({CNT_W{1'b1}})) return '1;
    return s[CNT_W-1:0];
  endfunction

  coal_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_sum;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [NEW_W-1:0] new_cnt;
  logic             coal_en, thr_hit, tmo_hit;

  assign new_cnt = popcount(ev_mask_i);
  assign cnt_sum = sat_add(cnt_q, new_cnt);
  assign coal_en = (thresh_i != '0) || (timeout_i != '0);
  assign thr_hit = (thresh_i != '0) && (cnt_sum >= thresh_i);
  assign tmo_hit = (timeout_i != '0) && (timer_q == timeout_i - TMR_W'(1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    if (!coal_en) begin
      state_d = IDLE;
      cnt_d   = '0;
      timer_d = '0;
    end else if (ack_i) begin
      // Events arriving in the ack cycle seed the next round instead of being dropped.
      timer_d = '0;
      cnt_d   = sat_add('0, new_cnt);
      state_d = (new_cnt != '0) ? ACCUM : IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (new_cnt != '0) begin
            cnt_d   = cnt_sum;
            state_d = thr_hit ? FIRE : ACCUM;
          end
        end
        ACCUM: begin
          cnt_d   = cnt_sum;
          timer_d = timer_q + TMR_W'(1);
          if (thr_hit || tmo_hit) state_d = FIRE;
        end
        FIRE: cnt_d = cnt_sum;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
    end
  end

  assign cnt_o      = cnt_q;
  assign state_o    = state_q;
  assign irq_coal_o = (state_q == FIRE);

endmodule

// File: rtl/ext_irq_ctrl.sv
// External-accelerator interrupt controller: per-channel level/edge capture into
// pending bits, masked vector output, coalesced line, and the register-bus front end.
module ext_irq_ctrl
  import ext_irq_ctrl_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int CNT_W = 8,
  parameter int TMR_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_CH-1:0]  src_irq_i,
  input  reg_req_t         reg_req_i,
  output reg_rsp_t         reg_rsp_o,
  output logic [N_CH-1:0]  irq_vec_o,
  output logic             irq_coal_o
);

  logic [N_CH-1:0]  src_q, pending_q, enable_q, mode_q, ev;
  logic [CNT_W-1:0] thresh_q, cnt;
  logic [TMR_W-1:0] timeout_q;
  coal_state_e      coal_state;

  logic [2:0]  off;
  logic        addr_err, wr_ok, ack;
  logic [31:0] wmask, wbits, rdata_sel;
  logic        unused_req;

  // Edge-mode channels only fire on a 0->1 transition of the source.
  assign ev = src_irq_i & ~(mode_q & src_q);

  assign off      = reg_req_i.addr[4:2];
  assign addr_err = (reg_req_i.addr[1:0] != 2'b00) || (off > OFF_COAL);
  assign wr_ok    = reg_req_i.valid && reg_req_i.write && !addr_err;
  assign ack      = wr_ok && (off == OFF_COAL);
  assign wmask    = strb_to_mask(reg_req_i.wstrb);
  assign wbits    = reg_req_i.wdata & wmask;

  assign unused_req = ^{reg_req_i, wmask, wbits};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      src_q     <= '0;
      pending_q <= '0;
      enable_q  <= '0;
      mode_q    <= '0;
      thresh_q  <= '0;
      timeout_q <= '0;
    end else begin
      src_q <= src_irq_i;
      // New events are ORed in after the W1C so a same-cycle set wins.
      if (wr_ok && (off == OFF_PENDING))
        pending_q <= (pending_q & ~wbits[N_CH-1:0]) | ev;
      else
        pending_q <= pending_q | ev;
      if (wr_ok && (off == OFF_ENABLE))
        enable_q <= (enable_q & ~wmask[N_CH-1:0]) | wbits[N_CH-1:0];
      if (wr_ok && (off == OFF_MODE))
        mode_q <= (mode_q & ~wmask[N_CH-1:0]) | wbits[N_CH-1:0];
      if (wr_ok && (off == OFF_THRESH))
        thresh_q <= (thresh_q & ~wmask[CNT_W-1:0]) | wbits[CNT_W-1:0];
      if (wr_ok && (off == OFF_TIMEOUT))
        timeout_q <= (timeout_q & ~wmask[TMR_W-1:0]) | wbits[TMR_W-1:0];
    end
  end

  ext_irq_coalescer #(
    .N_CH  (N_CH),
    .CNT_W (CNT_W),
    .TMR_W (TMR_W)
  ) u_coalescer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .ev_mask_i  (ev & enable_q),
    .thresh_i   (thresh_q),
    .timeout_i  (timeout_q),
    .ack_i      (ack),
    .cnt_o      (cnt),
    .state_o    (coal_state),
    .irq_coal_o (irq_coal_o)
  );

  always_comb begin
    rdata_sel = '0;
    unique case (off)
      OFF_PENDING: rdata_sel = 32'(pending_q);
      OFF_ENABLE:  rdata_sel = 32'(enable_q);
      OFF_MODE:    rdata_sel = 32'(mode_q);
      OFF_THRESH:  rdata_sel = 32'(thresh_q);
      OFF_TIMEOUT: rdata_sel = 32'(timeout_q);
      OFF_COAL:    rdata_sel = (32'(coal_state) << 16) | 32'(cnt);
      default:     rdata_sel = '0;
    endcase
  end

  assign reg_rsp_o.ready = 1'b1;
  assign reg_rsp_o.error = reg_req_i.valid && addr_err;
  assign reg_rsp_o.rdata = addr_err ? 32'd0 : rdata_sel;

  assign irq_vec_o = pending_q & enable_q;

endmodule
